// File: rtl/m31_pkg.sv
// Shared M31 field constants, operand type and the dot-accumulator FSM encoding.
package m31_pkg;

    localparam logic [30:0] M31_P          = 31'h7FFFFFFF;
    localparam int          M31_WIDTH      = 31;
    localparam int          M31_PROD_WIDTH = 62;

    typedef bit [M31_WIDTH-1:0] m31_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } acc_state_e;

endpackage

// File: rtl/m31_wide_mul.sv
// Registered 31x31 -> 62-bit exact multiplier, one cycle latency, valid/last sideband.
module m31_wide_mul
    import m31_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_i,
    input  logic                      last_i,
    input  m31_t                      a_i,
    input  m31_t                      b_i,
    output logic                      valid_o,
    output logic                      last_o,
    output logic [M31_PROD_WIDTH-1:0] prod_o
);

    logic                      valid_q;
    logic                      last_q;
    logic [M31_PROD_WIDTH-1:0] prod_q;
    logic [M31_PROD_WIDTH-1:0] prod_d;

    assign prod_d = M31_PROD_WIDTH'(a_i) * M31_PROD_WIDTH'(b_i);

    // Product only loads on an accepted beat so idle cycles leave stage 1 untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                prod_q <= prod_d;
                last_q <= last_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign prod_o  = prod_q;

endmodule

// File: rtl/m31_dot_accumulator.sv
// Exact multiply-accumulate over up to MAX_TERMS operand pairs; emits the wide
// unreduced sum for the downstream M31 reducer.
module m31_dot_accumulator
    import m31_pkg::*;
#(
    parameter int MAX_TERMS = 16,
    parameter int ACC_WIDTH = 62 + $clog2(MAX_TERMS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [30:0]                  in_a,
    input  logic [30:0]                  in_b,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_WIDTH-1:0]         out_data,
    output logic [$clog2(MAX_TERMS):0]   out_count,
    output logic                         out_trunc
);

    localparam int CNT_W = $clog2(MAX_TERMS) + 1;

    acc_state_e                 state_q;
    logic                       in_ready_q;
    logic                       out_valid_q;
    logic [ACC_WIDTH-1:0]       out_data_q;
    logic [CNT_W-1:0]           out_count_q;
    logic                       out_trunc_q;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       trunc_q;
    logic                       drain_step_q;
    logic [ACC_WIDTH-1:0]       acc_q, acc_d;
    logic                       acc_fresh_q;

    logic                       accept;
    logic                       end_beat;
    logic                       prod_valid;
    logic                       prod_last;
    logic [M31_PROD_WIDTH-1:0]  prod;

    assign accept   = in_valid && in_ready_q;
    assign end_beat = in_last || (cnt_q == CNT_W'(MAX_TERMS - 1));

    m31_wide_mul u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (accept),
        .last_i  (end_beat),
        .a_i     (in_a),
        .b_i     (in_b),
        .valid_o (prod_valid),
        .last_o  (prod_last),
        .prod_o  (prod)
    );

    // First product of a vector replaces whatever the previous vector left behind.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = acc_fresh_q ? ACC_WIDTH'(prod) : acc_q + ACC_WIDTH'(prod);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_count_q  <= '0;
            out_trunc_q  <= 1'b0;
            cnt_q        <= '0;
            trunc_q      <= 1'b0;
            drain_step_q <= 1'b0;
            acc_q        <= '0;
            acc_fresh_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        cnt_q   <= cnt_d;
                        state_q <= ACCUM;
                        if (end_beat) begin
                            state_q      <= DRAIN;
                            in_ready_q   <= 1'b0;
                            trunc_q      <= !in_last;
                            drain_step_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (prod_valid && prod_last) begin
                        drain_step_q <= 1'b1;
                    end else if (drain_step_q) begin
                        state_q     <= HOLD;
                        out_valid_q <= 1'b1;
                        out_data_q  <= acc_q;
                        out_count_q <= cnt_q;
                        out_trunc_q <= trunc_q;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        cnt_q       <= '0;
                        trunc_q     <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (prod_valid) begin
                acc_q       <= acc_d;
                acc_fresh_q <= 1'b0;
            end
            if (state_q == HOLD && out_ready) begin
                acc_fresh_q <= 1'b1;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_trunc = out_trunc_q;

endmodule

// File: tb/tb_m31_dot_accumulator.sv
// Directed plus randomized checks of m31_dot_accumulator against a plain-arithmetic sum-of-products model.
module tb_m31_dot_accumulator;

    localparam int ACC_W = 66;
    localparam int CNT_W = 5;
    localparam logic [127:0] P = 128'h7FFFFFFF;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [30:0]       in_a = '0;
    logic [30:0]       in_b = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ACC_W-1:0]  out_data;
    logic [CNT_W-1:0]  out_count;
    logic              out_trunc;

    int checks = 0;
    int errors = 0;

    m31_dot_accumulator #(.MAX_TERMS(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_trunc (out_trunc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic send_beat(input logic [30:0] a, input logic [30:0] b, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 128'(in_ready), 128'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [127:0] exp_sum, input int exp_cnt,
                              input logic exp_trunc, input int hold);
        int n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 128'(out_valid), 128'd1);
        check({tag, "_data"}, 128'(out_data), exp_sum);
        check({tag, "_count"}, 128'(out_count), 128'(exp_cnt));
        check({tag, "_trunc"}, 128'(out_trunc), 128'(exp_trunc));
        check({tag, "_mod"}, 128'(out_data) % P, exp_sum % P);
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, "_hold_data"}, 128'(out_data), exp_sum);
            check({tag, "_hold_ready"}, 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 128'(out_valid), 128'd0);
        check({tag, "_ready_back"}, 128'(in_ready), 128'd1);
        check({tag, "_data_kept"}, 128'(out_data), exp_sum);
        $display("vector %s sum=0x%0h count=%0d trunc=%0d", tag, exp_sum, exp_cnt, exp_trunc);
    endtask

    initial begin
        logic [127:0] sum;
        logic [30:0]  a, b;
        int           len;
        logic         lastf;
        logic         trunc;

        // Reset state
        step();
        step();
        check("rst_in_ready", 128'(in_ready), 128'd0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_data", 128'(out_data), 128'd0);
        check("rst_out_count", 128'(out_count), 128'd0);
        check("rst_out_trunc", 128'(out_trunc), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst_ready_rise", 128'(in_ready), 128'd1);

        // Single term with latency check
        send_beat(31'd3, 31'd5, 1'b1);
        check("lat_e0_valid", 128'(out_valid), 128'd0);
        check("lat_e0_ready", 128'(in_ready), 128'd0);
        step();
        check("lat_e1_valid", 128'(out_valid), 128'd0);
        step();
        check("lat_e2_valid", 128'(out_valid), 128'd1);
        get_result("single", 128'd15, 1, 1'b0, 0);

        // Worst-case magnitude
        sum = '0;
        for (int i = 0; i < 16; i++) begin
            send_beat(31'h7FFFFFFF, 31'h7FFFFFFF, i == 15);
            sum += 128'h7FFFFFFF * 128'h7FFFFFFF;
        end
        check("max_model", sum, 128'h3_FFFF_FFF0_0000_0010);
        get_result("max", 128'h3_FFFF_FFF0_0000_0010, 16, 1'b0, 0);

        // Gaps, then a long hold with ignored inputs
        send_beat(31'd1, 31'd2, 1'b0);
        step();
        step();
        send_beat(31'd3, 31'd4, 1'b0);
        step();
        send_beat(31'd5, 31'd6, 1'b1);
        in_valid = 1'b1;
        in_a     = 31'd9;
        in_b     = 31'd9;
        in_last  = 1'b1;
        get_result("gaps", 128'd44, 3, 1'b0, 5);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("gaps_no_ghost", 128'(out_valid), 128'd0);

        // Truncation at MAX_TERMS, 17th beat waits for the handshake
        for (int i = 0; i < 16; i++) send_beat(31'd1, 31'd1, 1'b0);
        in_valid = 1'b1;
        in_a     = 31'd2;
        in_b     = 31'd2;
        in_last  = 1'b1;
        check("trunc_blocked", 128'(in_ready), 128'd0);
        get_result("trunc", 128'd16, 16, 1'b1, 2);
        send_beat(31'd2, 31'd2, 1'b1);
        get_result("after_trunc", 128'd4, 1, 1'b0, 0);

        // Reset mid-vector
        send_beat(31'd11, 31'd13, 1'b0);
        send_beat(31'd17, 31'd19, 1'b0);
        send_beat(31'd23, 31'd29, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 128'(in_ready), 128'd0);
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        check("midrst_out_data", 128'(out_data), 128'd0);
        check("midrst_out_count", 128'(out_count), 128'd0);
        check("midrst_out_trunc", 128'(out_trunc), 128'd0);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("midrst_ready_rise", 128'(in_ready), 128'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("midrst_no_result", 128'(out_valid), 128'd0);
        end
        send_beat(31'd7, 31'd7, 1'b1);
        get_result("post_rst", 128'd49, 1, 1'b0, 0);

        // Randomized back-to-back vectors
        for (int v = 0; v < 1000; v++) begin
            len   = $urandom_range(1, 16);
            lastf = (len < 16) ? 1'b1 : 1'($urandom_range(0, 1));
            trunc = (len == 16) && !lastf;
            sum   = '0;
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 3))
                    0:       a = 31'h7FFFFFFF;
                    default: a = 31'($urandom);
                endcase
                b = 31'($urandom);
                sum += 128'(a) * 128'(b);
                send_beat(a, b, (i == len - 1) ? lastf : 1'b0);
                if ($urandom_range(0, 4) == 0) step();
            end
            get_result($sformatf("rnd%0d", v), sum, len, trunc, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
